// File: rtl/dmix_rate_detect.sv
// rtl/dmix_rate_detect.sv - LRCK period measurement, 48/96/192 kHz rate classification and lock tracking
`timescale 1ns/1ps
module dmix_rate_detect #(
   parameter int TOL        = 8,
   parameter int LOCK_COUNT = 4,
   parameter int TIMEOUT    = 1100
) (
   input  logic        clk245760,
   input  logic        rst_n,
   input  logic        lrck_in,
   output logic [1:0]  rate,
   output logic        locked,
   output logic [10:0] period,
   output logic        rate_change
);

   localparam int MW = $clog2(LOCK_COUNT + 1);

   localparam logic [10:0]   CNT_MAX    = 11'h7FF;
   localparam logic [10:0]   TIMEOUT_W  = 11'(TIMEOUT);
   localparam logic [11:0]   TOL_W      = 12'(TOL);
   localparam logic [10:0]   NOM_48K    = 11'd512;
   localparam logic [10:0]   NOM_96K    = 11'd256;
   localparam logic [10:0]   NOM_192K   = 11'd128;
   localparam logic [MW-1:0] MATCH_ONE  = MW'(1);
   localparam logic [MW-1:0] MATCH_LAST = MW'(LOCK_COUNT - 1);

   localparam logic [1:0] CLS_NONE = 2'd0;
   localparam logic [1:0] CLS_48K  = 2'd1;
   localparam logic [1:0] CLS_96K  = 2'd2;
   localparam logic [1:0] CLS_192K = 2'd3;

   typedef enum logic [1:0] {
      ST_UNLOCKED = 2'd0,
      ST_ACQUIRE  = 2'd1,
      ST_LOCKED   = 2'd2
   } state_t;

   state_t         state;
   logic           sync1;
   logic           sync2;
   logic           sync3;
   logic           lrck_rise;
   logic [10:0]    cnt;
   logic           armed;
   logic [1:0]     cap_class;
   logic [1:0]     cand;
   logic [MW-1:0]  match;
   logic           capture;
   logic           timeout_hit;

   // Inclusive window test in 12 bits so nominal-TOL and nominal+TOL cannot wrap
   function automatic logic in_window(input logic [10:0] p, input logic [10:0] nom);
      logic [11:0] lo;
      logic [11:0] hi;
      lo = {1'b0, nom} - TOL_W;
      hi = {1'b0, nom} + TOL_W;
      return ({1'b0, p} >= lo) && ({1'b0, p} <= hi);
   endfunction

   // Two-flop synchronizer on the asynchronous pad, third flop for edge detection
   always_ff @(posedge clk245760 or negedge rst_n) begin
      if (!rst_n) begin
         sync1 <= 1'b0;
         sync2 <= 1'b0;
         sync3 <= 1'b0;
      end else begin
         sync1 <= lrck_in;
         sync2 <= sync1;
         sync3 <= sync2;
      end
   end

   assign lrck_rise   = sync2 & ~sync3;
   assign capture     = lrck_rise & armed;
   // An edge in the same cycle as the timeout count takes priority
   assign timeout_hit = ~lrck_rise & (cnt == TIMEOUT_W);

   // Classify the value the counter holds at the moment an edge is detected
   always_comb begin
      cap_class = CLS_NONE;
      if (in_window(cnt, NOM_48K)) begin
         cap_class = CLS_48K;
      end else if (in_window(cnt, NOM_96K)) begin
         cap_class = CLS_96K;
      end else if (in_window(cnt, NOM_192K)) begin
         cap_class = CLS_192K;
      end
   end

   // Saturating period counter; the first edge after reset or timeout only arms capture
   always_ff @(posedge clk245760 or negedge rst_n) begin
      if (!rst_n) begin
         cnt    <= 11'd0;
         period <= 11'd0;
         armed  <= 1'b0;
      end else if (lrck_rise) begin
         cnt   <= 11'd1;
         armed <= 1'b1;
         if (armed) begin
            period <= cnt;
         end
      end else begin
         if (cnt != CNT_MAX) begin
            cnt <= cnt + 11'd1;
         end
         if (cnt == TIMEOUT_W) begin
            armed <= 1'b0;
         end
      end
   end

   // Lock state machine with registered rate/locked and a one-cycle rate_change pulse
   always_ff @(posedge clk245760 or negedge rst_n) begin
      if (!rst_n) begin
         state       <= ST_UNLOCKED;
         cand        <= CLS_NONE;
         match       <= '0;
         rate        <= CLS_NONE;
         locked      <= 1'b0;
         rate_change <= 1'b0;
      end else begin
         rate_change <= 1'b0;
         if (capture) begin
            case (state)
               ST_UNLOCKED: begin
                  if (cap_class != CLS_NONE) begin
                     cand  <= cap_class;
                     match <= MATCH_ONE;
                     state <= ST_ACQUIRE;
                  end
               end
               ST_ACQUIRE: begin
                  if (cap_class == CLS_NONE) begin
                     match <= '0;
                     state <= ST_UNLOCKED;
                  end else if (cap_class == cand) begin
                     match <= match + MATCH_ONE;
                     // This capture brings match up to the lock count
                     if (match == MATCH_LAST) begin
                        state       <= ST_LOCKED;
                        rate        <= cand;
                        locked      <= 1'b1;
                        rate_change <= 1'b1;
                     end
                  end else begin
                     cand  <= cap_class;
                     match <= MATCH_ONE;
                  end
               end
               ST_LOCKED: begin
                  if (cap_class != cand) begin
                     rate        <= CLS_NONE;
                     locked      <= 1'b0;
                     rate_change <= 1'b1;
                     if (cap_class == CLS_NONE) begin
                        match <= '0;
                        state <= ST_UNLOCKED;
                     end else begin
                        // A new valid rate seeds acquisition straight away
                        cand  <= cap_class;
                        match <= MATCH_ONE;
                        state <= ST_ACQUIRE;
                     end
                  end
               end
               default: begin
                  match <= '0;
                  state <= ST_UNLOCKED;
               end
            endcase
         end else if (timeout_hit) begin
            state       <= ST_UNLOCKED;
            match       <= '0;
            rate        <= CLS_NONE;
            locked      <= 1'b0;
            rate_change <= (rate != CLS_NONE);
         end
      end
   end

endmodule

// File: tb/tb_dmix_rate_detect.sv
// tb/tb_dmix_rate_detect.sv - scoreboard bench for dmix_rate_detect
`timescale 1ns/1ps
module tb_dmix_rate_detect;

   logic        clk245760;
   logic        rst_n;
   logic        lrck_in;
   logic [1:0]  rate;
   logic        locked;
   logic [10:0] period;
   logic        rate_change;

   typedef struct {
      logic [1:0]  rate;
      logic        locked;
      logic [10:0] period;
      logic        rc;
   } exp_t;

   exp_t exp_q[$];
   int   n_tests = 0;
   int   n_fail  = 0;
   int   rc_count = 0;

   dmix_rate_detect #(.TOL(8), .LOCK_COUNT(4), .TIMEOUT(1100)) dut (
      .clk245760   (clk245760),
      .rst_n       (rst_n),
      .lrck_in     (lrck_in),
      .rate        (rate),
      .locked      (locked),
      .period      (period),
      .rate_change (rate_change)
   );

   initial clk245760 = 1'b0;
   always #20 clk245760 = ~clk245760;

   // Pulse counter sampled away from the active edge
   always @(negedge clk245760) begin
      if (rst_n && rate_change === 1'b1) rc_count++;
   end

   // One LRCK period of n cycles starting with a rising edge; expectation for that edge is
   // queued at the edge and popped three cycles later when the registered result is due
   task automatic send(input string tag, input int n, input logic [1:0] r, input logic l,
                       input logic [10:0] p, input logic rc, input bit chk_pre);
      exp_t e;
      e.rate = r; e.locked = l; e.period = p; e.rc = rc;
      lrck_in = 1'b1;
      exp_q.push_back(e);
      repeat (2) @(negedge clk245760);
      if (chk_pre) begin
         n_tests++;
         if (locked !== 1'b0) begin
            n_fail++;
            $display("FAIL %s early_lock: got locked=%0b want 0", tag, locked);
         end
      end
      @(negedge clk245760);
      e = exp_q.pop_front();
      n_tests++;
      if (rate !== e.rate) begin
         n_fail++;
         $display("FAIL %s rate: got %0d want %0d", tag, rate, e.rate);
      end
      n_tests++;
      if (locked !== e.locked) begin
         n_fail++;
         $display("FAIL %s locked: got %0b want %0b", tag, locked, e.locked);
      end
      n_tests++;
      if (period !== e.period) begin
         n_fail++;
         $display("FAIL %s period: got %0d want %0d", tag, period, e.period);
      end
      n_tests++;
      if (rate_change !== e.rc) begin
         n_fail++;
         $display("FAIL %s rate_change: got %0b want %0b", tag, rate_change, e.rc);
      end
      repeat (n / 2 - 3) @(negedge clk245760);
      lrck_in = 1'b0;
      repeat (n - n / 2) @(negedge clk245760);
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      lrck_in = 1'b0;
      repeat (3) @(negedge clk245760);
      n_tests++;
      if ({rate, locked, period, rate_change} !== 15'd0) begin
         n_fail++;
         $display("FAIL reset_outputs: got rate=%0d locked=%0b period=%0d rc=%0b want all 0",
                  rate, locked, period, rate_change);
      end
      rst_n = 1'b1;
   endtask

   task automatic test_48k_lock();
      int rc0;
      rc0 = rc_count;
      send("lock48_e1", 512, 2'd0, 1'b0, 11'd0,   1'b0, 1'b0);
      send("lock48_e2", 512, 2'd0, 1'b0, 11'd512, 1'b0, 1'b0);
      send("lock48_e3", 512, 2'd0, 1'b0, 11'd512, 1'b0, 1'b0);
      send("lock48_e4", 512, 2'd0, 1'b0, 11'd512, 1'b0, 1'b0);
      send("lock48_e5", 512, 2'd1, 1'b1, 11'd512, 1'b1, 1'b1);
      n_tests++;
      if (rc_count - rc0 != 1) begin
         n_fail++;
         $display("FAIL lock48_pulses: got %0d want 1", rc_count - rc0);
      end
   endtask

   task automatic test_jitter();
      int rc0;
      rc0 = rc_count;
      send("jit_504", 504, 2'd1, 1'b1, 11'd512, 1'b0, 1'b0);
      send("jit_520", 520, 2'd1, 1'b1, 11'd504, 1'b0, 1'b0);
      send("jit_504b", 504, 2'd1, 1'b1, 11'd520, 1'b0, 1'b0);
      send("jit_520b", 520, 2'd1, 1'b1, 11'd504, 1'b0, 1'b0);
      send("jit_521", 521, 2'd1, 1'b1, 11'd520, 1'b0, 1'b0);
      send("jit_unlock", 512, 2'd0, 1'b0, 11'd521, 1'b1, 1'b0);
      n_tests++;
      if (rc_count - rc0 != 1) begin
         n_fail++;
         $display("FAIL jitter_pulses: got %0d want 1", rc_count - rc0);
      end
   endtask

   task automatic test_rate_switch();
      int rc0;
      send("sw_a", 512, 2'd0, 1'b0, 11'd512, 1'b0, 1'b0);
      send("sw_b", 512, 2'd0, 1'b0, 11'd512, 1'b0, 1'b0);
      send("sw_c", 512, 2'd0, 1'b0, 11'd512, 1'b0, 1'b0);
      send("sw_lock48", 256, 2'd1, 1'b1, 11'd512, 1'b1, 1'b0);
      rc0 = rc_count;
      send("sw_unlock", 256, 2'd0, 1'b0, 11'd256, 1'b1, 1'b0);
      send("sw_m2", 256, 2'd0, 1'b0, 11'd256, 1'b0, 1'b0);
      send("sw_m3", 256, 2'd0, 1'b0, 11'd256, 1'b0, 1'b0);
      send("sw_lock96", 128, 2'd2, 1'b1, 11'd256, 1'b1, 1'b0);
      n_tests++;
      if (rc_count - rc0 != 2) begin
         n_fail++;
         $display("FAIL switch_pulses: got %0d want 2", rc_count - rc0);
      end
   endtask

   task automatic test_192k_invalid();
      send("q_unlock96", 128, 2'd0, 1'b0, 11'd128, 1'b1, 1'b0);
      send("q_m2", 128, 2'd0, 1'b0, 11'd128, 1'b0, 1'b0);
      send("q_m3", 128, 2'd0, 1'b0, 11'd128, 1'b0, 1'b0);
      send("q_lock192", 300, 2'd3, 1'b1, 11'd128, 1'b1, 1'b0);
      send("q_invalid", 128, 2'd0, 1'b0, 11'd300, 1'b1, 1'b0);
      send("q_fresh1", 128, 2'd0, 1'b0, 11'd128, 1'b0, 1'b0);
      send("q_fresh2", 128, 2'd0, 1'b0, 11'd128, 1'b0, 1'b0);
      send("q_fresh3", 128, 2'd0, 1'b0, 11'd128, 1'b0, 1'b0);
      send("q_relock", 256, 2'd3, 1'b1, 11'd128, 1'b1, 1'b0);
   endtask

   task automatic test_timeout();
      send("to_unlock", 256, 2'd0, 1'b0, 11'd256, 1'b1, 1'b0);
      send("to_m2", 256, 2'd0, 1'b0, 11'd256, 1'b0, 1'b0);
      send("to_m3", 256, 2'd0, 1'b0, 11'd256, 1'b0, 1'b0);
      send("to_lock96", 256, 2'd2, 1'b1, 11'd256, 1'b1, 1'b0);
      // Last edge was driven 256 cycles ago; expiry becomes visible 1103 cycles after that drive
      repeat (1102 - 256) @(negedge clk245760);
      n_tests++;
      if (locked !== 1'b1) begin
         n_fail++;
         $display("FAIL timeout_early: got locked=%0b want 1", locked);
      end
      @(negedge clk245760);
      n_tests++;
      if ({rate, locked, rate_change} !== 4'b0001) begin
         n_fail++;
         $display("FAIL timeout_unlock: got rate=%0d locked=%0b rc=%0b want 0 0 1",
                  rate, locked, rate_change);
      end
      repeat (200) @(negedge clk245760);
      send("to_rearm", 256, 2'd0, 1'b0, 11'd256, 1'b0, 1'b0);
      send("to_acq1", 256, 2'd0, 1'b0, 11'd256, 1'b0, 1'b0);
   endtask

   task automatic test_reset_mid_lock();
      int rc0;
      send("rs_m2", 256, 2'd0, 1'b0, 11'd256, 1'b0, 1'b0);
      send("rs_m3", 256, 2'd0, 1'b0, 11'd256, 1'b0, 1'b0);
      send("rs_lock", 256, 2'd2, 1'b1, 11'd256, 1'b1, 1'b0);
      rc0 = rc_count;
      rst_n = 1'b0;
      #1;
      n_tests++;
      if ({rate, locked, period, rate_change} !== 15'd0) begin
         n_fail++;
         $display("FAIL async_reset: got rate=%0d locked=%0b period=%0d rc=%0b want all 0",
                  rate, locked, period, rate_change);
      end
      repeat (3) @(negedge clk245760);
      rst_n = 1'b1;
      send("rs_e1", 256, 2'd0, 1'b0, 11'd0,   1'b0, 1'b0);
      n_tests++;
      if (rc_count != rc0) begin
         n_fail++;
         $display("FAIL reset_pulse: got %0d pulses want 0", rc_count - rc0);
      end
      send("rs_e2", 256, 2'd0, 1'b0, 11'd256, 1'b0, 1'b0);
      send("rs_e3", 256, 2'd0, 1'b0, 11'd256, 1'b0, 1'b0);
      send("rs_e4", 256, 2'd0, 1'b0, 11'd256, 1'b0, 1'b0);
      send("rs_e5", 1100, 2'd2, 1'b1, 11'd256, 1'b1, 1'b1);
   endtask

   task automatic test_edge_vs_timeout();
      // Edge lands exactly when the counter reaches the timeout: it is captured as a period
      send("evt_edge", 512, 2'd0, 1'b0, 11'd1100, 1'b1, 1'b0);
      send("evt_armed", 512, 2'd0, 1'b0, 11'd512, 1'b0, 1'b0);
   endtask

   initial begin
      test_reset();
      test_48k_lock();
      test_jitter();
      test_rate_switch();
      test_192k_invalid();
      test_timeout();
      test_reset_mid_lock();
      test_edge_vs_timeout();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/dmix_rate_detect.md
Name: dmix_rate_detect

Overview:
Measures the period of an externally supplied LRCK against the local 24.576 MHz master clock. Classifies the incoming stream as 48, 96 or 192 kHz and reports lock status. Sits at the input end of the mixer, consuming the clock domain the clock generator produces. Its rate output selects which derived clock (1x/2x/4x) the downstream input path uses.

Parameters:
TOL, 8, allowed deviation in master-clock cycles from nominal period (512/256/128)
LOCK_COUNT, 4, consecutive same-class periods required to declare lock
TIMEOUT, 1100, cycles without an LRCK rising edge before forced unlock (must be < 2047)

Ports:
clk245760  input  1  24.576 MHz master clock; all logic on rising edge
rst_n  input  1  asynchronous, active-low reset
lrck_in  input  1  external LRCK, asynchronous to clk245760
rate  output  2  0=none, 1=48k, 2=96k, 3=192k
locked  output  1  high while rate is valid
period  output  11  last captured LRCK period in clk245760 cycles
rate_change  output  1  one-cycle pulse whenever rate changes value

Behaviour:
- Reset (asynchronous on rst_n low): rate=0, locked=0, period=0, rate_change=0. State=UNLOCKED, counters=0, sync flops=0, armed=0. Reset mid-operation drops lock immediately, with no rate_change pulse.
- Sync and edge detect: lrck_in passes through a 2-flop synchronizer, then a third flop for edge detection.
  - Rising edge = sync2 & ~sync3.
  - Latency from pad transition to detected edge: 3 cycles. Only rising edges are used.
- Period counter cnt, 11 bits:
  - Increments every cycle and saturates at 2047.
  - On a detected edge: period<=cnt and cnt<=1, so edges 512 cycles apart give period=512.
  - First edge after reset or timeout only sets armed=1; its capture is discarded and period is not updated.
- Classification of each captured value p, combinational:
  - |p-512|<=TOL gives class 1; |p-256|<=TOL gives 2; |p-128|<=TOL gives 3; otherwise invalid.
  - Comparisons are inclusive.
- States:
  - UNLOCKED: the first valid-class capture loads cand=class, match=1, then goes to ACQUIRE. Invalid captures stay here.
  - ACQUIRE: a capture with class==cand increments match. A capture with a different valid class reloads cand and sets match=1. An invalid capture returns to UNLOCKED with match=0. When match reaches LOCK_COUNT, the next cycle enters LOCKED with rate=cand and locked=1.
  - LOCKED: a capture with the same class stays here. An invalid or different-class capture goes to UNLOCKED with rate=0 and locked=0. A different valid class also seeds cand=class and match=1, then goes directly to ACQUIRE.
- Timeout: in any state, cnt reaching TIMEOUT with no edge forces UNLOCKED, rate=0, locked=0, armed=0, match=0.
- rate_change: asserted for exactly one cycle, in the cycle after rate's registered value differs from its previous value. Covers both lock and unlock transitions.
- Timing: rate and locked update 1 cycle after the detection cycle of the deciding edge. Lock therefore needs LOCK_COUNT+1 edges after reset.
- Simultaneous edge and cnt==TIMEOUT in the same cycle: the edge wins, with normal capture and no timeout.
- period holds its last value across unlock; it is cleared only by reset.

Test Plan:
- 48k lock: 512-cycle square LRCK from reset. Required: locked=0 through 4th edge; locked=1 and rate=1 one cycle after 5th detected edge; single rate_change pulse; period=512.
- Jitter tolerance: locked at 48k, periods alternating 504/520. Required: stays locked, no rate_change. Then one period of 521. Required: locked=0, rate=0, rate_change pulse, period=521.
- Rate switch: locked 48k, then switch to 256-cycle periods. Required: unlock on the first 256 capture; relock with rate=2 after 3 further 256-cycle periods (match counts from 1); two rate_change pulses in total.
- 192k and invalid: 128-cycle periods give rate=3. A 300-cycle period gives an unlock, and the next 128 starts a fresh ACQUIRE.
- Timeout: locked at 96k, LRCK held low. Required: unlock 1100 cycles after the last captured edge, with rate_change. The next edge only re-arms, with period unchanged.
- Reset mid-lock: rst_n low for 3 cycles while locked. Required: outputs 0 immediately (asynchronous), no rate_change pulse; relock needs 5 edges after release.
